// File: rtl/fio_pkg.sv
// rtl/fio_pkg.sv - shared state encoding, error bits and sizing helpers for the boot/dump engine
package fio_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_CLEAR = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DUMP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_LOAD  = S_LOAD,
      ST_CLEAR = S_CLEAR,
      ST_RUN   = S_RUN,
      ST_DUMP  = S_DUMP,
      ST_DONE  = S_DONE
   } fio_state_e;

   localparam int ERR_ORDER   = 0;
   localparam int ERR_TIMEOUT = 1;

   // Channel index width; a single channel still needs one select bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fio_skid2.sv
// rtl/fio_skid2.sv - 2-entry read-return buffer with credit tracking for the dump stream
module fio_skid2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         issue,
   input  logic         issue_last,
   output logic         can_issue,
   input  logic [W-1:0] rd_data,
   output logic [W-1:0] m_tdata,
   output logic         m_tlast,
   output logic         m_tvalid,
   input  logic         m_tready
);

   logic         inflight_q, inflight_d;
   logic         inflight_last_q, inflight_last_d;
   logic [W-1:0] ent_data_q [2];
   logic [W-1:0] ent_data_d [2];
   logic [1:0]   ent_last_q, ent_last_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         pop;
   logic [2:0]   occ;

   // Capture returning read data, pop on handshake, and grant a read credit
   // counting the word that leaves this cycle so a held-high ready streams 1/cycle.
   always_comb begin
      m_tvalid        = (count_q != 2'd0);
      m_tdata         = ent_data_q[rd_ptr_q];
      m_tlast         = ent_last_q[rd_ptr_q];
      pop             = m_tvalid && m_tready;
      occ             = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
      can_issue       = (occ < 3'd2);
      inflight_d      = issue;
      inflight_last_d = issue && issue_last;
      ent_data_d      = ent_data_q;
      ent_last_d      = ent_last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      if (inflight_q) begin
         ent_data_d[wr_ptr_q] = rd_data;
         ent_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
   end

   // Buffer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         ent_data_q[0]   <= '0;
         ent_data_q[1]   <= '0;
         ent_last_q      <= 2'b00;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         ent_data_q      <= ent_data_d;
         ent_last_q      <= ent_last_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         count_q         <= count_d;
      end
   end

endmodule

// File: rtl/fio_boot_dump_ctrl.sv
// rtl/fio_boot_dump_ctrl.sv - load images, run the task manager, dump a MEM row window
module fio_boot_dump_ctrl
   import fio_pkg::*;
#(
   parameter int          NUM_CH      = 4,
   parameter int          DATA_W      = 256,
   parameter int          ADDR_W      = 12,
   parameter int          DUMP_FIRST  = 1,
   parameter int          DUMP_LAST   = 16,
   parameter int unsigned RUN_TIMEOUT = 1000000,
   localparam int         CH_W        = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [CH_W-1:0]   ld_ch,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic [NUM_CH-1:0] wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              tm_clear,
   output logic              tm_start,
   input  logic              tm_finished,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic [31:0]       run_cycles,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err
);

   fio_state_e        state_q, state_d;
   logic              armed_q, armed_d;
   logic [CH_W-1:0]   prev_ch_q, prev_ch_d;
   logic [ADDR_W-1:0] addr_cnt_q [NUM_CH];
   logic [ADDR_W-1:0] addr_cnt_d [NUM_CH];
   logic [NUM_CH-1:0] wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [1:0]        err_q, err_d;
   logic [31:0]       run_cycles_q, run_cycles_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              issued_all_q, issued_all_d;
   logic              ld_accept;
   logic              ch_ok;
   logic              rd_issue;
   logic              rd_issue_last;
   logic              sk_can_issue;

   fio_skid2 #(
      .W (DATA_W)
   ) u_dump_buf (
      .clk        (clk),
      .rst        (rst),
      .issue      (rd_issue),
      .issue_last (rd_issue_last),
      .can_issue  (sk_can_issue),
      .rd_data    (rd_data),
      .m_tdata    (dump_data),
      .m_tlast    (dump_last),
      .m_tvalid   (dump_valid),
      .m_tready   (dump_ready)
   );

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign rd_addr    = rd_addr_q;
   assign run_cycles = run_cycles_q;
   assign err        = err_q;
   assign tm_clear   = (state_q == ST_CLEAR);
   assign tm_start   = (state_q == ST_RUN) || (state_q == ST_DUMP);
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done       = (state_q == ST_DONE);

   // Sequencing: load routing, clear pulse, run counting/timeout, dump read issue.
   always_comb begin
      state_d       = state_q;
      armed_d       = 1'b1;
      prev_ch_d     = prev_ch_q;
      addr_cnt_d    = addr_cnt_q;
      wr_en_d       = '0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      err_d         = err_q;
      run_cycles_d  = run_cycles_q;
      rd_addr_d     = rd_addr_q;
      issued_all_d  = issued_all_q;
      rd_issue      = 1'b0;
      rd_issue_last = 1'b0;
      // ld_ready stays low while reset is held and for the first cycle after it.
      ld_ready      = armed_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
      ld_accept     = ld_valid && ld_ready;
      ch_ok         = ({1'b0, ld_ch} < (CH_W + 1)'(NUM_CH)) && (ld_ch >= prev_ch_q);

      case (state_q)
         ST_IDLE, ST_LOAD: begin
            if (ld_accept) begin
               if (ch_ok) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (ld_ch == CH_W'(i)) begin
                        wr_en_d[i]    = 1'b1;
                        wr_addr_d     = addr_cnt_q[i];
                        addr_cnt_d[i] = addr_cnt_q[i] + ADDR_W'(1);
                     end
                  end
                  wr_data_d = ld_data;
                  prev_ch_d = ld_ch;
               end else begin
                  err_d[ERR_ORDER] = 1'b1;
               end
               state_d = ld_last ? ST_CLEAR : ST_LOAD;
            end
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            run_cycles_d = (run_cycles_q == 32'hFFFF_FFFF) ? run_cycles_q : run_cycles_q + 32'd1;
            // Finished wins over a coincident timeout.
            if (tm_finished) begin
               state_d      = ST_DUMP;
               rd_addr_d    = ADDR_W'(DUMP_FIRST);
               issued_all_d = 1'b0;
            end else if ((RUN_TIMEOUT != 0) && (run_cycles_d >= RUN_TIMEOUT)) begin
               err_d[ERR_TIMEOUT] = 1'b1;
               state_d            = ST_DUMP;
               rd_addr_d          = ADDR_W'(DUMP_FIRST);
               issued_all_d       = 1'b0;
            end
         end
         ST_DUMP: begin
            if (sk_can_issue && !issued_all_q) begin
               rd_issue      = 1'b1;
               rd_issue_last = (rd_addr_q == ADDR_W'(DUMP_LAST));
               if (rd_issue_last) begin
                  issued_all_d = 1'b1;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end
            if (dump_valid && dump_ready && dump_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state registers; reset aborts to IDLE values at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         armed_q      <= 1'b0;
         prev_ch_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            addr_cnt_q[i] <= '0;
         end
         wr_en_q      <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         err_q        <= 2'b00;
         run_cycles_q <= 32'd0;
         rd_addr_q    <= '0;
         issued_all_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         prev_ch_q    <= prev_ch_d;
         addr_cnt_q   <= addr_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         err_q        <= err_d;
         run_cycles_q <= run_cycles_d;
         rd_addr_q    <= rd_addr_d;
         issued_all_q <= issued_all_d;
      end
   end

endmodule

// File: tb/tb_fio_boot_dump_ctrl.sv
// tb/tb_fio_boot_dump_ctrl.sv - directed scoreboard bench for fio_boot_dump_ctrl
module tb_fio_boot_dump_ctrl;

   localparam int NUM_CH      = 5;
   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 8;
   localparam int DUMP_FIRST  = 1;
   localparam int DUMP_LAST   = 16;
   localparam int RUN_TIMEOUT = 50;

   logic              clk;
   logic              rst;
   logic              ld_valid;
   logic              ld_ready;
   logic [2:0]        ld_ch;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic [NUM_CH-1:0] wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              tm_clear;
   logic              tm_start;
   logic              tm_finished;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic              dump_last;
   logic [31:0]       run_cycles;
   logic              busy;
   logic              done;
   logic [1:0]        err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] wr_q[$];
   int          dump_q[$];
   int          m_prev;
   int          m_addr[NUM_CH];
   int          words;
   int          span;

   fio_boot_dump_ctrl #(
      .NUM_CH      (NUM_CH),
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .DUMP_FIRST  (DUMP_FIRST),
      .DUMP_LAST   (DUMP_LAST),
      .RUN_TIMEOUT (RUN_TIMEOUT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_ch       (ld_ch),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .tm_clear    (tm_clear),
      .tm_start    (tm_start),
      .tm_finished (tm_finished),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_data   (dump_data),
      .dump_last   (dump_last),
      .run_cycles  (run_cycles),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // MEM model: row r holds r*0x11, returned one cycle after the address.
   always @(posedge clk) rd_data <= 32'(rd_addr) * 32'h11;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wr_pack(input logic [4:0] en, input logic [7:0] a, input logic [31:0] d);
      return {19'b0, en, a, d};
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_prev = 0;
      for (int i = 0; i < NUM_CH; i++) m_addr[i] = 0;
      wr_q.delete();
      dump_q.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      cycle();
   endtask

   task automatic send(input int ch, input logic [31:0] d, input bit last);
      int          k;
      bit          exp_wr;
      logic [63:0] exp_v;
      logic [4:0]  onehot;
      logic [7:0]  a;
      k = 0;
      while (!ld_ready && k < 20) begin
         cycle();
         k++;
      end
      check("ld_ready_wait", ld_ready, 1);
      ld_valid = 1'b1;
      ld_ch    = ch[2:0];
      ld_data  = d;
      ld_last  = last;
      exp_wr   = (ch < NUM_CH) && (ch >= m_prev);
      if (exp_wr) begin
         onehot = 5'(1 << ch);
         a      = 8'(m_addr[ch]);
         wr_q.push_back(wr_pack(onehot, a, d));
         m_addr[ch] = (m_addr[ch] + 1) % 256;
         m_prev     = ch;
      end
      cycle();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (wr_q.size() != 0) begin
         exp_v = wr_q.pop_front();
         check("wr_beat", wr_pack(wr_en, wr_addr, wr_data), exp_v);
      end else begin
         check("wr_dropped", {59'b0, wr_en}, 0);
      end
   endtask

   task automatic dump_phase(input bit toggle, input int stop_after, output int got, output int span_o);
      bit [3:0]    pat;
      int          cyc;
      int          first;
      int          last_cyc;
      int          exp_row;
      bit          fin;
      bit          held_v;
      logic [31:0] held_d;
      pat      = 4'b1001;
      cyc      = 0;
      first    = -1;
      last_cyc = -1;
      got      = 0;
      fin      = 1'b0;
      held_v   = 1'b0;
      held_d   = '0;
      for (int r = DUMP_FIRST; r <= DUMP_LAST; r++) dump_q.push_back(r);
      while (!fin && cyc < 300) begin
         dump_ready = toggle ? pat[cyc % 4] : 1'b1;
         if (held_v) begin
            check("dump_hold_valid", dump_valid, 1);
            check("dump_hold_data", dump_data, held_d);
         end
         if (dump_valid && dump_ready) begin
            exp_row = (dump_q.size() != 0) ? dump_q.pop_front() : -1;
            check("dump_data", dump_data, 32'(exp_row) * 32'h11);
            check("dump_last", dump_last, (exp_row == DUMP_LAST) ? 1 : 0);
            got++;
            if (first < 0) first = cyc;
            last_cyc = cyc;
            if (dump_last || (got == stop_after)) fin = 1'b1;
         end
         held_v = dump_valid && !dump_ready;
         held_d = dump_data;
         cycle();
         cyc++;
      end
      check("dump_budget", fin, 1);
      dump_ready = 1'b0;
      span_o = last_cyc - first;
   endtask

   initial begin
      rst         = 1'b0;
      ld_valid    = 1'b0;
      ld_ch       = '0;
      ld_data     = '0;
      ld_last     = 1'b0;
      tm_finished = 1'b0;
      dump_ready  = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_outputs", {ld_ready, wr_en, tm_clear, tm_start, dump_valid, dump_last, busy, done, err}, 0);
      check("rst_counters", {rd_addr, run_cycles, wr_addr}, 0);
      rst = 1'b1;
      cycle();
      cycle();
      check("idle_ready", {ld_ready, busy, done}, 3'b100);

      // Run 1: in-order load, finished after 37 RUN cycles, full-rate dump.
      for (int i = 0; i < 3; i++) send(0, 32'hA000_0000 + i, 1'b0);
      for (int i = 0; i < 2; i++) send(1, 32'hB100_0000 + i, 1'b0);
      send(3, 32'hC300_0000, 1'b1);
      check("clear_pulse", {tm_clear, tm_start, ld_ready, busy}, 4'b1001);
      cycle();
      check("run_start", {tm_clear, tm_start}, 2'b01);
      repeat (36) cycle();
      tm_finished = 1'b1;
      cycle();
      tm_finished = 1'b0;
      check("run_cycles_37", run_cycles, 37);
      check("err_clean", err, 0);
      dump_phase(1'b0, 0, words, span);
      check("dump_words", words, 16);
      check("dump_back_to_back", span, 15);
      check("done_state", {done, tm_start, busy, ld_ready, dump_valid}, 5'b10000);
      check("run_cycles_frozen", run_cycles, 37);

      // Run 2: order/range drops, finished coincident with timeout, stalled dump.
      apply_reset();
      send(1, 32'h1111_0001, 1'b0);
      send(0, 32'h1111_0002, 1'b0);
      send(5, 32'h1111_0003, 1'b0);
      check("err_order", err, 2'b01);
      send(1, 32'h1111_0004, 1'b1);
      cycle();
      repeat (49) cycle();
      tm_finished = 1'b1;
      cycle();
      tm_finished = 1'b0;
      check("run_cycles_50", run_cycles, 50);
      check("finish_beats_timeout", err, 2'b01);
      dump_phase(1'b1, 0, words, span);
      check("dump_words_stalled", words, 16);
      check("done_state2", {done, tm_start}, 2'b10);

      // Run 3: timeout, then reset pulled mid-dump and a fresh load.
      apply_reset();
      send(2, 32'h2222_0000, 1'b1);
      cycle();
      repeat (49) cycle();
      check("pre_timeout", {err, run_cycles}, {2'b00, 32'd49});
      cycle();
      check("timeout_err", err, 2'b10);
      check("timeout_cycles", run_cycles, 50);
      check("timeout_running", {tm_start, busy}, 2'b11);
      dump_phase(1'b1, 5, words, span);
      check("partial_dump", words, 5);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_outputs", {ld_ready, wr_en, tm_clear, tm_start, dump_valid, dump_last, busy, done, err}, 0);
      check("async_rst_counters", {rd_addr, run_cycles}, 0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      send(0, 32'h3333_0000, 1'b0);
      send(0, 32'h3333_0001, 1'b1);
      check("fresh_err", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
